// File: rtl/debounce_multi.sv
// Multi-channel symmetric debouncer: 2-FF sync, polarity normalisation, press/release
// filtering, clean level plus rise/fall event pulses. Long-press pulse with DEBOUNCE_HOLD_EN.
module debounce_multi #(
  parameter int WIDTH        = 1,
  parameter int TIMEOUT      = 1000,
  parameter int ACTIVE_LOW   = 0,
  parameter int HOLD_TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
`ifdef DEBOUNCE_HOLD_EN
  ,
  output logic [WIDTH-1:0] hold_pulse
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam bit PARAMS_OK = (WIDTH >= 1) && (TIMEOUT >= 1) && (HOLD_TIMEOUT >= 1);

`ifdef DEBOUNCE_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_TIMEOUT - 1);
`endif

  if (!PARAMS_OK) begin : g_bad_params
    $error("debounce_multi: WIDTH, TIMEOUT and HOLD_TIMEOUT must all be >= 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic             sync_p0;
    logic             sync_p1;
    logic             level;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;

    // Stage p0/p1: synchronizer with polarity folded in, so 0 is always "released".
    // The filter then runs on sync_p1; any cycle of agreement with level restarts the count.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_p0 <= 1'b0;
        sync_p1 <= 1'b0;
        level   <= 1'b0;
        rise    <= 1'b0;
        fall    <= 1'b0;
        cnt     <= '0;
      end else begin
        sync_p0 <= data_in[i] ^ POL;
        sync_p1 <= sync_p0;
        rise    <= 1'b0;
        fall    <= 1'b0;
        if (sync_p1 == level) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          level <= sync_p1;
          rise  <= sync_p1;
          fall  <= ~sync_p1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign data_out[i]   = level;
    assign rise_pulse[i] = rise;
    assign fall_pulse[i] = fall;

`ifdef DEBOUNCE_HOLD_EN
    logic [HOLD_W-1:0] hcnt;
    logic              hold;

    // Saturating press-duration counter; saturation is what limits it to one pulse per press.
    always_ff @(posedge clk) begin
      if (rst) begin
        hcnt <= '0;
        hold <= 1'b0;
      end else begin
        hold <= 1'b0;
        if (!level) begin
          hcnt <= '0;
        end else if (hcnt != HOLD_MAX) begin
          hcnt <= hcnt + HOLD_W'(1);
          hold <= (hcnt == HOLD_PRE);
        end
      end
    end

    assign hold_pulse[i] = hold;
`endif
  end

endmodule
